// File: rtl/ntt_sequencer.sv
// ntt_sequencer: stage/address sequencer for a bank of parallel NTT cores.
// Runs LOG_N stages. Each stage issues STAGE_LEN reads (READ), then waits
// PIPE_LATENCY cycles (DRAIN) for the last write. Writebacks come from a
// PIPE_LATENCY-deep delay line of {valid, read_address}.
//
// Optional feature: define NTT_SEQ_STALL_EN to add the `stall` input.
// While READ is stalled, read_address holds and an invalid slot enters the
// delay line.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle request to run a transform (IDLE only)
//   stall                 (NTT_SEQ_STALL_EN only) hold READ for one cycle
//   busy                  high through READ and DRAIN of every stage
//   done                  one-cycle completion pulse
//   log_m                 current stage index
//   i                     butterfly-group index (mode 1 only)
//   read_address          read address (0 outside READ)
//   mode                  twiddle-addressing mode
//   read_select/write_select         ping-pong bank selects
//   upper/lower_write_enable         delayed read valid
//   upper/lower_write_address        delayed read address
module ntt_sequencer #(
  parameter int unsigned LOG_N          = 12,
  parameter int unsigned LOG_CORE_COUNT = 5,
  parameter int unsigned STAGE_LEN      = 32,
  parameter int unsigned PIPE_LATENCY   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef NTT_SEQ_STALL_EN
  input  logic       stall,
`endif
  output logic       busy,
  output logic       done,
  output logic [3:0] log_m,
  output logic [9:0] i,
  output logic [8:0] read_address,
  output logic [1:0] mode,
  output logic       read_select,
  output logic       write_select,
  output logic       upper_write_enable,
  output logic       lower_write_enable,
  output logic [8:0] upper_write_address,
  output logic [8:0] lower_write_address
);

  localparam int unsigned AW  = 9;
  localparam int unsigned LMW = 4;
  localparam int unsigned DCW = 4;
  localparam int unsigned IW  = 10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [AW-1:0]  raddr_q, raddr_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;
  logic [LMW-1:0] log_m_q, log_m_d;
  logic           rsel_q, rsel_d;
  logic           wsel_q, wsel_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [1:0]     mode_q, mode_d;
  logic [IW-1:0]  i_q, i_d;
  logic           stall_int;
  logic           in_valid;

  // Writeback delay line
  logic           dl_v [PIPE_LATENCY];
  logic [AW-1:0]  dl_a [PIPE_LATENCY];

`ifdef NTT_SEQ_STALL_EN
  assign stall_int = stall;
`else
  assign stall_int = 1'b0;
`endif

  // A read slot is real only in an unstalled READ cycle
  assign in_valid = (state_q == S_READ) && !stall_int;

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    dcnt_d  = dcnt_q;
    log_m_d = log_m_q;
    rsel_d  = rsel_q;
    wsel_d  = wsel_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    mode_d  = 2'd0;
    i_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          raddr_d = '0;
          log_m_d = '0;
        end
      end
      S_READ: begin
        if (!stall_int) begin
          if (raddr_q == AW'(STAGE_LEN - 1)) begin
            state_d = S_DRAIN;
            raddr_d = '0;
            dcnt_d  = '0;
          end else begin
            raddr_d = raddr_q + AW'(1);
          end
        end
      end
      S_DRAIN: begin
        // Last drain cycle carries the final write of the stage
        if (dcnt_q == DCW'(PIPE_LATENCY - 1)) begin
          dcnt_d = '0;
          rsel_d = ~rsel_q;
          wsel_d = ~wsel_q;
          if (log_m_q == LMW'(LOG_N - 1)) begin
            state_d = S_DONE;
            log_m_d = '0;
          end else begin
            state_d = S_READ;
            log_m_d = log_m_q + LMW'(1);
          end
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);

    // Twiddle mode from the stage index the outputs will show next cycle
    if (32'(log_m_d) < LOG_CORE_COUNT) begin
      mode_d = 2'd0;
    end else if (32'(log_m_d) == LOG_CORE_COUNT) begin
      mode_d = 2'd1;
    end else begin
      mode_d = 2'd2;
    end

    if (mode_d == 2'd1) begin
      i_d = {1'b0, raddr_d};
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      dcnt_q  <= '0;
      log_m_q <= '0;
      rsel_q  <= 1'b0;
      wsel_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 2'd0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      dcnt_q  <= dcnt_d;
      log_m_q <= log_m_d;
      rsel_q  <= rsel_d;
      wsel_q  <= wsel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      i_q     <= i_d;
    end
  end

  // Delay line: the slot at the tail appears PIPE_LATENCY cycles after its read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(PIPE_LATENCY); k++) begin
        dl_v[k] <= 1'b0;
        dl_a[k] <= '0;
      end
    end else begin
      dl_v[0] <= in_valid;
      dl_a[0] <= raddr_q;
      for (int k = 1; k < int'(PIPE_LATENCY); k++) begin
        dl_v[k] <= dl_v[k-1];
        dl_a[k] <= dl_a[k-1];
      end
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign log_m               = log_m_q;
  assign i                   = i_q;
  assign read_address        = raddr_q;
  assign mode                = mode_q;
  assign read_select         = rsel_q;
  assign write_select        = wsel_q;
  assign upper_write_enable  = dl_v[PIPE_LATENCY-1];
  assign lower_write_enable  = dl_v[PIPE_LATENCY-1];
  assign upper_write_address = dl_a[PIPE_LATENCY-1];
  assign lower_write_address = dl_a[PIPE_LATENCY-1];

endmodule

// File: tb/tb_ntt_sequencer.sv
// Directed bench for ntt_sequencer at default parameters.
module tb_ntt_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
`ifdef NTT_SEQ_STALL_EN
  logic       stall;
`endif
  logic       busy, done;
  logic [3:0] log_m;
  logic [9:0] i;
  logic [8:0] read_address;
  logic [1:0] mode;
  logic       read_select, write_select;
  logic       upper_write_enable, lower_write_enable;
  logic [8:0] upper_write_address, lower_write_address;

  always #5 clk = ~clk;

  ntt_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
`ifdef NTT_SEQ_STALL_EN
    .stall               (stall),
`endif
    .busy                (busy),
    .done                (done),
    .log_m               (log_m),
    .i                   (i),
    .read_address        (read_address),
    .mode                (mode),
    .read_select         (read_select),
    .write_select        (write_select),
    .upper_write_enable  (upper_write_enable),
    .lower_write_enable  (lower_write_enable),
    .upper_write_address (upper_write_address),
    .lower_write_address (lower_write_address)
  );

  typedef struct {
    int         cyc;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] log_m;
    logic [8:0] raddr;
    logic [1:0] mode;
    logic [9:0] i;
    logic       sel;
    logic       we;
    logic [8:0] waddr;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  // Run monitors
  int   busy_cnt, done_cnt, done_cyc, toggles, wr_cnt, seq_err, we_bad, wexp;
  logic prev_sel;

  function automatic vec_t mk(input int c, input logic s, input logic b, input logic d,
                              input logic [3:0] lm, input logic [8:0] ra, input logic [1:0] md,
                              input logic [9:0] ii, input logic sl, input logic w,
                              input logic [8:0] wa);
    vec_t v;
    v.cyc = c; v.start = s; v.busy = b; v.done = d; v.log_m = lm; v.raddr = ra;
    v.mode = md; v.i = ii; v.sel = sl; v.we = w; v.waddr = wa;
    return v;
  endfunction

  function automatic logic [63:0] obs();
    return 64'({busy, done, log_m, read_address, mode, i, read_select, write_select,
                upper_write_enable, lower_write_enable, upper_write_address,
                lower_write_address});
  endfunction

  function automatic logic [63:0] expv(input vec_t v);
    return 64'({v.busy, v.done, v.log_m, v.raddr, v.mode, v.i, v.sel, v.sel,
                v.we, v.we, v.waddr, v.waddr});
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1; toggles = 0;
    wr_cnt = 0; seq_err = 0; we_bad = 0; wexp = 0;
    prev_sel = read_select;
  endtask

  // Advance one cycle, sample 1 time unit after the edge, update monitors
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (read_select != prev_sel) toggles++;
    prev_sel = read_select;
    if (upper_write_enable || lower_write_enable) begin
      wr_cnt++;
      if (!busy) we_bad++;
      if (!(upper_write_enable && lower_write_enable) ||
          upper_write_address != 9'(wexp) || lower_write_address != 9'(wexp))
        seq_err++;
      wexp = (wexp == 31) ? 0 : wexp + 1;
    end
  endtask

  initial begin
    logic [3:0] lm41, lm42;
    logic [8:0] ra7;
    logic       b41;

    rst = 1'b1;
    start = 1'b0;
`ifdef NTT_SEQ_STALL_EN
    stall = 1'b0;
`endif
    cyc = 0;
    #2;
    check("reset_hold", obs(), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();

    //          cyc  st b  d  lm  ra  md i  sel we wa
    vecs[0]  = mk(0,   1, 0, 0, 0,  0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1,   0, 1, 0, 0,  0,  0, 0, 0, 0, 0);
    vecs[2]  = mk(6,   0, 1, 0, 0,  5,  0, 0, 0, 0, 0);
    vecs[3]  = mk(7,   0, 1, 0, 0,  6,  0, 0, 0, 1, 0);
    vecs[4]  = mk(32,  0, 1, 0, 0,  31, 0, 0, 0, 1, 25);
    vecs[5]  = mk(33,  0, 1, 0, 0,  0,  0, 0, 0, 1, 26);
    vecs[6]  = mk(38,  0, 1, 0, 0,  0,  0, 0, 0, 1, 31);
    vecs[7]  = mk(39,  0, 1, 0, 1,  0,  0, 0, 1, 0, 0);
    vecs[8]  = mk(40,  0, 1, 0, 1,  1,  0, 0, 1, 0, 0);
    vecs[9]  = mk(100, 1, 1, 0, 2,  23, 0, 0, 0, 1, 17);
    vecs[10] = mk(160, 0, 1, 0, 4,  7,  0, 0, 0, 1, 1);
    vecs[11] = mk(200, 0, 1, 0, 5,  9,  1, 9, 1, 1, 3);
    vecs[12] = mk(240, 0, 1, 0, 6,  11, 2, 0, 0, 1, 5);
    vecs[13] = mk(419, 0, 1, 0, 11, 0,  2, 0, 1, 0, 0);
    vecs[14] = mk(450, 0, 1, 0, 11, 31, 2, 0, 1, 1, 25);
    vecs[15] = mk(456, 0, 1, 0, 11, 0,  2, 0, 1, 1, 31);
    vecs[16] = mk(457, 0, 0, 1, 0,  0,  0, 0, 0, 0, 0);
    vecs[17] = mk(458, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0);

    // Full default transform, start at cycle 0, ignored start at cycle 100
    cyc = 0;
    mon_clear();
    for (int k = 0; k < NV; k++) begin
      while (cyc < vecs[k].cyc) step();
      check($sformatf("vec%0d_cyc%0d", k, vecs[k].cyc), obs(), expv(vecs[k]));
      if (vecs[k].start) start = 1'b1;
    end
    check("busy_cycles", 64'(busy_cnt), 64'd456);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'd457);
    check("sel_toggles", 64'(toggles), 64'd12);
    check("write_count", 64'(wr_cnt), 64'd384);
    check("write_seq_err", 64'(seq_err), 64'd0);
    check("we_outside_busy", 64'(we_bad), 64'd0);

    // Asynchronous reset mid-transform
    cyc = 0;
    mon_clear();
    start = 1'b1;
    while (cyc < 50) step();
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_outputs", obs(), 64'd0);
    step();
    rst = 1'b0;
    mon_clear();
    for (int k = 0; k < 100; k++) step();
    check("post_rst_writes", 64'(wr_cnt), 64'd0);
    check("post_rst_busy", 64'(busy_cnt), 64'd0);

    // New start after reset runs a full transform
    cyc = 0;
    mon_clear();
    start = 1'b1;
    while (cyc < 470) step();
    check("rerun_done_cycle", 64'(done_cyc), 64'd457);
    check("rerun_write_count", 64'(wr_cnt), 64'd384);
    check("rerun_write_seq_err", 64'(seq_err), 64'd0);

`ifdef NTT_SEQ_STALL_EN
    // Three stalled READ cycles in stage 0 stretch it to 41 cycles
    cyc = 0;
    mon_clear();
    start = 1'b1;
    lm41 = '0; lm42 = '0; ra7 = '0; b41 = 1'b0;
    while (cyc < 45) begin
      step();
      stall = (cyc >= 5 && cyc <= 7);
      if (cyc == 7) ra7 = read_address;
      if (cyc == 41) begin
        lm41 = log_m;
        b41 = busy;
      end
      if (cyc == 42) lm42 = log_m;
    end
    stall = 1'b0;
    check("stall_raddr_held", 64'(ra7), 64'd4);
    check("stall_stage0_last", 64'({b41, lm41}), 64'({1'b1, 4'd0}));
    check("stall_stage1_first", 64'(lm42), 64'd1);
    check("stall_write_count", 64'(wr_cnt), 64'd32);
    check("stall_write_seq_err", 64'(seq_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
